// File: rtl/matmul_engine_if.sv
// Loader request/response pair and C-element output stream of matmul_engine.
// master: the engine side; slave: the loader/compiler side.
interface matmul_engine_if #(
  parameter int unsigned ELEM_W   = 8,
  parameter int unsigned MAX_SIZE = 32,
  parameter int unsigned OUT_W    = 8
);
  localparam int unsigned IdxW = $clog2(MAX_SIZE);
  localparam int unsigned VecW = MAX_SIZE * ELEM_W;

  // Run control from the loader
  logic            complete;
  logic [IdxW:0]   dim_m;
  logic [IdxW:0]   dim_k;
  logic [IdxW:0]   dim_n;
  // Loader request / response
  logic            new_request;
  logic [IdxW-1:0] row_req;
  logic [IdxW-1:0] col_req;
  logic            val_rows;
  logic [IdxW-1:0] row_in;
  logic [IdxW-1:0] col_in;
  logic [VecW-1:0] matA_row;
  logic [VecW-1:0] matB_col;
  // C element stream
  logic [OUT_W-1:0] matrix_val;
  logic [IdxW-1:0]  row_out;
  logic [IdxW-1:0]  col_out;
  logic             valid_out;
  logic             out_ready;
  logic             done;

  modport master (
    input  complete, dim_m, dim_k, dim_n,
    input  val_rows, row_in, col_in, matA_row, matB_col, out_ready,
    output new_request, row_req, col_req,
    output matrix_val, row_out, col_out, valid_out, done
  );

  modport slave (
    output complete, dim_m, dim_k, dim_n,
    output val_rows, row_in, col_in, matA_row, matB_col, out_ready,
    input  new_request, row_req, col_req,
    input  matrix_val, row_out, col_out, valid_out, done
  );
endinterface

// File: rtl/matmul_engine.sv
// Matrix-multiply core: fetches one A row / B column pair per C element, reduces it with
// LANES parallel MACs per cycle and streams C out in row-major order with its address.
module matmul_engine #(
  parameter int unsigned ELEM_W   = 8,
  parameter int unsigned MAX_SIZE = 32,
  parameter int unsigned LANES    = 4,
  parameter int unsigned OUT_W    = 8,
  parameter bit          SATURATE = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  matmul_engine_if.master bus
);
  localparam int unsigned IdxW     = $clog2(MAX_SIZE);
  localparam int unsigned DimW     = IdxW + 1;
  localparam int unsigned AccW     = 2 * ELEM_W + IdxW + 1;
  localparam int unsigned MaxBeats = MAX_SIZE / LANES;
  localparam int unsigned BeatW    = $clog2(MaxBeats + 1);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StMac, StEmit, StDone} state_e;

  state_e            state_q, state_d;
  logic              complete_q, complete_d;
  logic              complete_dly_q, complete_dly_d;
  logic [DimW-1:0]   dim_m_q, dim_m_d, dim_k_q, dim_k_d, dim_n_q, dim_n_d;
  logic [DimW-1:0]   i_q, i_d, j_q, j_d;
  logic [BeatW-1:0]  beat_q, beat_d;
  logic [AccW-1:0]   acc_q, acc_d;
  logic [ELEM_W-1:0] a_q [MAX_SIZE];
  logic [ELEM_W-1:0] a_d [MAX_SIZE];
  logic [ELEM_W-1:0] b_q [MAX_SIZE];
  logic [ELEM_W-1:0] b_d [MAX_SIZE];

  logic              new_request_q, new_request_d;
  logic [IdxW-1:0]   row_req_q, row_req_d, col_req_q, col_req_d;
  logic              valid_out_q, valid_out_d;
  logic [OUT_W-1:0]  matrix_val_q, matrix_val_d;
  logic [IdxW-1:0]   row_out_q, row_out_d, col_out_q, col_out_d;
  logic              done_q, done_d;

  logic [AccW-1:0]     beat_sum;
  logic [IdxW-1:0]     lane_idx;
  logic [2*ELEM_W-1:0] lane_prod;
  int unsigned         beats_total;
  logic                resp_match;

  // Clamp or wrap the accumulator into the output width.
  function automatic logic [OUT_W-1:0] clip(input logic [AccW-1:0] v);
    if (SATURATE && ((v >> OUT_W) != '0)) return '1;
    return v[OUT_W-1:0];
  endfunction

  // Sum of this beat's LANES products; elements at or beyond dim_k are masked out.
  always_comb begin
    beat_sum  = '0;
    lane_idx  = '0;
    lane_prod = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_idx  = IdxW'(32'(beat_q) * LANES + l);
      lane_prod = a_q[lane_idx] * b_q[lane_idx];
      if ({1'b0, lane_idx} < dim_k_q) beat_sum = beat_sum + AccW'(lane_prod);
    end
  end

  // Next state, counters, datapath and registered outputs derived from the next state.
  always_comb begin
    state_d        = state_q;
    complete_d     = bus.complete;
    complete_dly_d = complete_q;
    dim_m_d        = dim_m_q;
    dim_k_d        = dim_k_q;
    dim_n_d        = dim_n_q;
    i_d            = i_q;
    j_d            = j_q;
    beat_d         = beat_q;
    acc_d          = acc_q;
    a_d            = a_q;
    b_d            = b_q;
    beats_total    = (32'(dim_k_q) + LANES - 1) / LANES;
    resp_match     = bus.val_rows && (bus.row_in == i_q[IdxW-1:0]) &&
                     (bus.col_in == j_q[IdxW-1:0]);

    unique case (state_q)
      StIdle: begin
        // complete is registered first, so the run starts on its delayed rising edge
        if (complete_q && !complete_dly_q) begin
          dim_m_d = bus.dim_m;
          dim_k_d = bus.dim_k;
          dim_n_d = bus.dim_n;
          i_d     = '0;
          j_d     = '0;
          state_d = ((bus.dim_m == '0) || (bus.dim_n == '0)) ? StDone : StReq;
        end
      end
      StReq: state_d = StWait;
      StWait: begin
        if (resp_match) begin
          for (int unsigned e = 0; e < MAX_SIZE; e++) begin
            a_d[e] = bus.matA_row[e*ELEM_W +: ELEM_W];
            b_d[e] = bus.matB_col[e*ELEM_W +: ELEM_W];
          end
          acc_d   = '0;
          beat_d  = '0;
          state_d = (dim_k_q == '0) ? StEmit : StMac;
        end
      end
      StMac: begin
        acc_d  = acc_q + beat_sum;
        beat_d = beat_q + 1'b1;
        if (32'(beat_q) + 1 >= beats_total) state_d = StEmit;
      end
      StEmit: begin
        if (bus.out_ready) begin
          if (j_q + 1'b1 == dim_n_q) begin
            j_d     = '0;
            i_d     = i_q + 1'b1;
            state_d = (i_q + 1'b1 == dim_m_q) ? StDone : StReq;
          end else begin
            j_d     = j_q + 1'b1;
            state_d = StReq;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    new_request_d = (state_d == StReq);
    row_req_d     = (state_d == StReq) ? i_d[IdxW-1:0] : '0;
    col_req_d     = (state_d == StReq) ? j_d[IdxW-1:0] : '0;
    valid_out_d   = (state_d == StEmit);
    matrix_val_d  = (state_d == StEmit) ? clip(acc_d) : '0;
    row_out_d     = (state_d == StEmit) ? i_d[IdxW-1:0] : '0;
    col_out_d     = (state_d == StEmit) ? j_d[IdxW-1:0] : '0;
    done_d        = (state_d == StDone);
  end

  // All state and outputs; reset aborts a run and clears every output at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      complete_q     <= 1'b0;
      complete_dly_q <= 1'b0;
      dim_m_q        <= '0;
      dim_k_q        <= '0;
      dim_n_q        <= '0;
      i_q            <= '0;
      j_q            <= '0;
      beat_q         <= '0;
      acc_q          <= '0;
      a_q            <= '{default: '0};
      b_q            <= '{default: '0};
      new_request_q  <= 1'b0;
      row_req_q      <= '0;
      col_req_q      <= '0;
      valid_out_q    <= 1'b0;
      matrix_val_q   <= '0;
      row_out_q      <= '0;
      col_out_q      <= '0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      complete_q     <= complete_d;
      complete_dly_q <= complete_dly_d;
      dim_m_q        <= dim_m_d;
      dim_k_q        <= dim_k_d;
      dim_n_q        <= dim_n_d;
      i_q            <= i_d;
      j_q            <= j_d;
      beat_q         <= beat_d;
      acc_q          <= acc_d;
      a_q            <= a_d;
      b_q            <= b_d;
      new_request_q  <= new_request_d;
      row_req_q      <= row_req_d;
      col_req_q      <= col_req_d;
      valid_out_q    <= valid_out_d;
      matrix_val_q   <= matrix_val_d;
      row_out_q      <= row_out_d;
      col_out_q      <= col_out_d;
      done_q         <= done_d;
    end
  end

  assign bus.new_request = new_request_q;
  assign bus.row_req     = row_req_q;
  assign bus.col_req     = col_req_q;
  assign bus.valid_out   = valid_out_q;
  assign bus.matrix_val  = matrix_val_q;
  assign bus.row_out     = row_out_q;
  assign bus.col_out     = col_out_q;
  assign bus.done        = done_q;
endmodule
